// File: rtl/pointer_centroid_detect.sv
`default_nettype none
// ============================================================================
//  Module   : pointer_centroid_detect
//  Brief    : Counts pixels matching a pointer colour window over one frame,
//             accumulates their X/Y coordinates, divides at end of frame and
//             emits a one-cycle detect pulse with the centroid position.
//  Options  : DETECT_SMOOTH_EN - average each new centroid with the previous
//             reported position (first detection after reset loads directly).
//  Revision : 1.0 - initial release
// ============================================================================
module pointer_centroid_detect #(
  parameter logic [9:0] R_MIN      = 10'd700,
  parameter logic [9:0] G_MAX      = 10'd300,
  parameter logic [9:0] B_MAX      = 10'd300,
  parameter int         H_ACTIVE   = 800,
  parameter int         V_ACTIVE   = 600,
  parameter int         MIN_PIXELS = 20
) (
  input  logic        clk_write,
  input  logic        rst,
  input  logic [9:0]  i_R,
  input  logic [9:0]  i_G,
  input  logic [9:0]  i_B,
  input  logic [15:0] i_X_pos,
  input  logic [15:0] i_Y_pos,
  input  logic        new_frame,
  input  logic        end_frame,
  output logic        detect,
  output logic [15:0] o_X_pos,
  output logic [15:0] o_Y_pos,
  output logic        busy
);

  localparam logic [15:0] c_h_active   = 16'(H_ACTIVE);
  localparam logic [15:0] c_v_active   = 16'(V_ACTIVE);
  localparam logic [19:0] c_min_pixels = 20'(MIN_PIXELS);
  localparam logic [19:0] c_cnt_max    = 20'hFFFFF;
  localparam logic [15:0] c_x_rst      = 16'd801;
  localparam logic [15:0] c_y_rst      = 16'd601;

  localparam logic [1:0] c_st_accum = 2'd0;
  localparam logic [1:0] c_st_div   = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [31:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [19:0] dsr_q, dsr_d;
  logic [31:0] quo_x_q, quo_x_d, quo_y_q, quo_y_d;
  logic [19:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [4:0]  bit_q, bit_d;
  logic        detect_q, detect_d;
  logic [15:0] x_q, x_d, y_q, y_d;
`ifdef DETECT_SMOOTH_EN
  logic        valid_q, valid_d;
`endif

  logic match;
  logic accept;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [51:0] div_step(input logic [19:0] rem,
                                           input logic [31:0] quo,
                                           input logic [19:0] dsr);
    logic [20:0] shifted;
    logic [20:0] diff;
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dsr};
    if (diff[20]) div_step = {shifted[19:0], quo[30:0], 1'b0};
    else          div_step = {diff[19:0],    quo[30:0], 1'b1};
  endfunction

  assign match  = (i_R >= R_MIN) && (i_G <= G_MAX) && (i_B <= B_MAX) &&
                  (i_X_pos < c_h_active) && (i_Y_pos < c_v_active);
  // end_frame only counts while idle; it also restarts accumulation for the new frame
  assign accept = end_frame && (state_q == c_st_accum);

  // Accumulators: restart on a frame boundary, otherwise add matches until cnt saturates
  always_comb begin
    cnt_d   = cnt_q;
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    if (new_frame || accept) begin
      cnt_d   = match ? 20'd1 : 20'd0;
      sum_x_d = match ? {16'd0, i_X_pos} : 32'd0;
      sum_y_d = match ? {16'd0, i_Y_pos} : 32'd0;
    end else if (match && (cnt_q != c_cnt_max)) begin
      cnt_d   = cnt_q + 20'd1;
      sum_x_d = sum_x_q + {16'd0, i_X_pos};
      sum_y_d = sum_y_q + {16'd0, i_Y_pos};
    end
  end

  // Next-state logic: divide only when enough pixels matched, 32 bit steps, one DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_accum: if (accept && (cnt_q >= c_min_pixels)) state_d = c_st_div;
      c_st_div:   if (bit_q == 5'd31) state_d = c_st_done;
      c_st_done:  state_d = c_st_accum;
      default:    state_d = c_st_accum;
    endcase
  end

  // Divider datapath: snapshot the pre-pixel accumulators, then one quotient bit per cycle
  always_comb begin
    dsr_d   = dsr_q;
    quo_x_d = quo_x_q;
    quo_y_d = quo_y_q;
    rem_x_d = rem_x_q;
    rem_y_d = rem_y_q;
    bit_d   = bit_q;
    if (accept) begin
      dsr_d   = cnt_q;
      quo_x_d = sum_x_q;
      quo_y_d = sum_y_q;
      rem_x_d = 20'd0;
      rem_y_d = 20'd0;
      bit_d   = 5'd0;
    end else if (state_q == c_st_div) begin
      {rem_x_d, quo_x_d} = div_step(rem_x_q, quo_x_q, dsr_q);
      {rem_y_d, quo_y_d} = div_step(rem_y_q, quo_y_q, dsr_q);
      bit_d = bit_q + 5'd1;
    end
  end

  // Output logic: publish the centroid and raise detect while in DONE
  always_comb begin
    detect_d = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    busy     = (state_q == c_st_div);
`ifdef DETECT_SMOOTH_EN
    valid_d  = valid_q;
`endif
    if (state_q == c_st_done) begin
      detect_d = 1'b1;
`ifdef DETECT_SMOOTH_EN
      valid_d  = 1'b1;
      if (valid_q) begin
        x_d = 16'(({1'b0, x_q} + {1'b0, quo_x_q[15:0]} + 17'd1) >> 1);
        y_d = 16'(({1'b0, y_q} + {1'b0, quo_y_q[15:0]} + 17'd1) >> 1);
      end else begin
        x_d = quo_x_q[15:0];
        y_d = quo_y_q[15:0];
      end
`else
      x_d = quo_x_q[15:0];
      y_d = quo_y_q[15:0];
`endif
    end
  end

  // State register
  always_ff @(posedge clk_write) begin
    if (!rst) state_q <= c_st_accum;
    else      state_q <= state_d;
  end

  // Accumulator and divider registers
  always_ff @(posedge clk_write) begin
    if (!rst) begin
      cnt_q   <= 20'd0;
      sum_x_q <= 32'd0;
      sum_y_q <= 32'd0;
      dsr_q   <= 20'd0;
      quo_x_q <= 32'd0;
      quo_y_q <= 32'd0;
      rem_x_q <= 20'd0;
      rem_y_q <= 20'd0;
      bit_q   <= 5'd0;
    end else begin
      cnt_q   <= cnt_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      dsr_q   <= dsr_d;
      quo_x_q <= quo_x_d;
      quo_y_q <= quo_y_d;
      rem_x_q <= rem_x_d;
      rem_y_q <= rem_y_d;
      bit_q   <= bit_d;
    end
  end

  // Output registers; reset parks the position off-screen
  always_ff @(posedge clk_write) begin
    if (!rst) begin
      detect_q <= 1'b0;
      x_q      <= c_x_rst;
      y_q      <= c_y_rst;
`ifdef DETECT_SMOOTH_EN
      valid_q  <= 1'b0;
`endif
    end else begin
      detect_q <= detect_d;
      x_q      <= x_d;
      y_q      <= y_d;
`ifdef DETECT_SMOOTH_EN
      valid_q  <= valid_d;
`endif
    end
  end

  assign detect  = detect_q;
  assign o_X_pos = x_q;
  assign o_Y_pos = y_q;

endmodule
`default_nettype wire

// File: tb/tb_pointer_centroid_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pointer_centroid_detect
//  Brief    : Self-checking bench for pointer_centroid_detect with a frame-level
//             reference model (integer sums and division).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pointer_centroid_detect;

  logic        clk_write = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  i_R = '0, i_G = '0, i_B = '0;
  logic [15:0] i_X_pos = '0, i_Y_pos = '0;
  logic        new_frame = 1'b0, end_frame = 1'b0;
  logic        detect, busy;
  logic [15:0] o_X_pos, o_Y_pos;

  pointer_centroid_detect dut (
    .clk_write (clk_write),
    .rst       (rst),
    .i_R       (i_R),
    .i_G       (i_G),
    .i_B       (i_B),
    .i_X_pos   (i_X_pos),
    .i_Y_pos   (i_Y_pos),
    .new_frame (new_frame),
    .end_frame (end_frame),
    .detect    (detect),
    .o_X_pos   (o_X_pos),
    .o_Y_pos   (o_Y_pos),
    .busy      (busy)
  );

  always #5 clk_write = ~clk_write;

  int checks = 0, failures = 0;
  int cyc = 0;

  // Reference model state
  longint m_cnt = 0, m_sx = 0, m_sy = 0, m_snc = 1, m_snx = 0, m_sny = 0;
  int     m_e0 = 0;
  bit     m_pend = 0;
  int     m_x = 801, m_y = 601;
  bit     m_valid = 0;
  int     exp_pulses = 0, exp_last_det = -1;
  int     obs_pulses = 0, obs_last_det = -1, busy_err = 0;

  // Drive one pixel, advance one clock, update the model, then observe the DUT.
  task automatic step(input int r, input int g, input int b, input int x, input int y,
                      input bit nf, input bit ef, input bit rv);
    bit match, accept;
    int qx, qy;
    i_R = 10'(r); i_G = 10'(g); i_B = 10'(b);
    i_X_pos = 16'(x); i_Y_pos = 16'(y);
    new_frame = nf; end_frame = ef; rst = rv;
    @(posedge clk_write);
    cyc++;
    if (!rv) begin
      m_cnt = 0; m_sx = 0; m_sy = 0; m_pend = 0;
      m_x = 801; m_y = 601; m_valid = 0;
    end else begin
      match  = (r >= 700) && (g <= 300) && (b <= 300) && (x < 800) && (y < 600);
      accept = ef && !m_pend;
      if (m_pend && cyc == m_e0 + 33) begin
        qx = int'(m_snx / m_snc);
        qy = int'(m_sny / m_snc);
`ifdef DETECT_SMOOTH_EN
        if (m_valid) begin
          qx = (m_x + qx + 1) / 2;
          qy = (m_y + qy + 1) / 2;
        end
        m_valid = 1;
`endif
        m_x = qx; m_y = qy; m_pend = 0;
        exp_pulses++; exp_last_det = cyc;
      end
      if (accept && m_cnt >= 20) begin
        m_pend = 1; m_e0 = cyc;
        m_snc = m_cnt; m_snx = m_sx; m_sny = m_sy;
      end
      if (nf || accept) begin
        m_cnt = match ? 1 : 0;
        m_sx  = match ? x : 0;
        m_sy  = match ? y : 0;
      end else if (match && m_cnt < 1048575) begin
        m_cnt++; m_sx += x; m_sy += y;
      end
    end
    #1;
    if (detect === 1'b1) begin obs_pulses++; obs_last_det = cyc; end
    if (busy !== (m_pend && cyc <= m_e0 + 31)) busy_err++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic fill(input int n, input int x, input int y, input bit nf_first);
    for (int i = 0; i < n; i++) step(800, 100, 100, x, y, nf_first && (i == 0), 0, 1);
  endtask

  task automatic test_reset;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    checks++; if (detect !== 1'b0) begin failures++; $display("FAIL reset_detect: got %0b expected 0", detect); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (o_X_pos !== 16'd801) begin failures++; $display("FAIL reset_x: got %0d expected 801", o_X_pos); end
    checks++; if (o_Y_pos !== 16'd601) begin failures++; $display("FAIL reset_y: got %0d expected 601", o_Y_pos); end
  endtask

  task automatic test_no_match;
    int p0;
    p0 = obs_pulses;
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1023), $urandom_range(301, 1023), $urandom_range(0, 1023),
           $urandom_range(0, 799), $urandom_range(0, 599), i == 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(40);
    checks++; if (obs_pulses != p0) begin failures++; $display("FAIL nomatch_pulses: got %0d expected %0d", obs_pulses - p0, 0); end
    checks++; if (o_X_pos !== 16'd801) begin failures++; $display("FAIL nomatch_x: got %0d expected 801", o_X_pos); end
    checks++; if (o_Y_pos !== 16'd601) begin failures++; $display("FAIL nomatch_y: got %0d expected 601", o_Y_pos); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nomatch_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_square;
    int p0, e0;
    bit in_sq;
    p0 = obs_pulses;
    for (int y = 198; y < 212; y++)
      for (int x = 96; x < 114; x++) begin
        in_sq = (x >= 100) && (x <= 109) && (y >= 200) && (y <= 209);
        step(in_sq ? 900 : 500, 100, 100, x, y, (x == 96) && (y == 198), 0, 1);
      end
    step(0, 0, 0, 0, 0, 0, 1, 1);
    e0 = cyc;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL square_busy: got %0b expected 1", busy); end
    idle(40);
    checks++; if (obs_pulses - p0 != 1) begin failures++; $display("FAIL square_pulses: got %0d expected 1", obs_pulses - p0); end
    checks++; if (obs_last_det != e0 + 33) begin failures++; $display("FAIL square_latency: got edge %0d expected %0d", obs_last_det, e0 + 33); end
    checks++; if (o_X_pos !== 16'd104) begin failures++; $display("FAIL square_x: got %0d expected 104", o_X_pos); end
    checks++; if (o_Y_pos !== 16'd204) begin failures++; $display("FAIL square_y: got %0d expected 204", o_Y_pos); end
  endtask

  task automatic test_below_min;
    int p0;
    p0 = obs_pulses;
    fill(19, 30, 30, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(40);
    checks++; if (obs_pulses != p0) begin failures++; $display("FAIL belowmin_pulses: got %0d expected 0", obs_pulses - p0); end
    checks++; if (o_X_pos !== 16'd104) begin failures++; $display("FAIL belowmin_x: got %0d expected 104", o_X_pos); end
    checks++; if (o_Y_pos !== 16'd204) begin failures++; $display("FAIL belowmin_y: got %0d expected 204", o_Y_pos); end
  endtask

  task automatic test_back_to_back;
    int p0, e0;
    p0 = obs_pulses;
    busy_err = 0;
    fill(30, 300, 400, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    e0 = cyc;
    idle(9);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(30);
    checks++; if (obs_pulses - p0 != 1) begin failures++; $display("FAIL b2b_pulses: got %0d expected 1", obs_pulses - p0); end
    checks++; if (obs_last_det != e0 + 33) begin failures++; $display("FAIL b2b_latency: got edge %0d expected %0d", obs_last_det, e0 + 33); end
    checks++; if (o_X_pos !== 16'(m_x)) begin failures++; $display("FAIL b2b_x: got %0d expected %0d", o_X_pos, m_x); end
    checks++; if (o_Y_pos !== 16'(m_y)) begin failures++; $display("FAIL b2b_y: got %0d expected %0d", o_Y_pos, m_y); end
    checks++; if (busy_err != 0) begin failures++; $display("FAIL b2b_busy: got %0d busy errors expected 0", busy_err); end
`ifndef DETECT_SMOOTH_EN
    checks++; if (o_X_pos !== 16'd300 || o_Y_pos !== 16'd400) begin failures++; $display("FAIL b2b_pos: got %0d,%0d expected 300,400", o_X_pos, o_Y_pos); end
`endif
  endtask

  task automatic test_nf_ef;
    int p0;
    p0 = obs_pulses;
    fill(20, 50, 60, 1);
    step(800, 100, 100, 5, 5, 1, 1, 1);
    fill(19, 5, 5, 0);
    idle(20);
    checks++; if (obs_pulses - p0 != 1) begin failures++; $display("FAIL nfef_pulses1: got %0d expected 1", obs_pulses - p0); end
    checks++; if (o_X_pos !== 16'(m_x)) begin failures++; $display("FAIL nfef_x1: got %0d expected %0d", o_X_pos, m_x); end
`ifndef DETECT_SMOOTH_EN
    checks++; if (o_X_pos !== 16'd50 || o_Y_pos !== 16'd60) begin failures++; $display("FAIL nfef_snapshot: got %0d,%0d expected 50,60", o_X_pos, o_Y_pos); end
`endif
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(40);
    checks++; if (obs_pulses - p0 != 2) begin failures++; $display("FAIL nfef_pulses2: got %0d expected 2", obs_pulses - p0); end
    checks++; if (o_Y_pos !== 16'(m_y)) begin failures++; $display("FAIL nfef_y2: got %0d expected %0d", o_Y_pos, m_y); end
`ifndef DETECT_SMOOTH_EN
    checks++; if (o_X_pos !== 16'd5 || o_Y_pos !== 16'd5) begin failures++; $display("FAIL nfef_newframe: got %0d,%0d expected 5,5", o_X_pos, o_Y_pos); end
`endif
  endtask

  task automatic test_random;
    int n;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(15, 120);
      for (int i = 0; i < n; i++)
        step($urandom_range(650, 1023), $urandom_range(0, 350), $urandom_range(0, 350),
             $urandom_range(0, 850), $urandom_range(0, 650), i == 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1, 1);
      idle(38);
      checks++; if (o_X_pos !== 16'(m_x) || o_Y_pos !== 16'(m_y)) begin failures++; $display("FAIL random_pos frame %0d: got %0d,%0d expected %0d,%0d", f, o_X_pos, o_Y_pos, m_x, m_y); end
      checks++; if (obs_pulses != exp_pulses || obs_last_det != exp_last_det) begin failures++; $display("FAIL random_pulse frame %0d: got %0d@%0d expected %0d@%0d", f, obs_pulses, obs_last_det, exp_pulses, exp_last_det); end
    end
  endtask

  task automatic test_reset_mid_div;
    int p0;
    p0 = obs_pulses;
    fill(25, 10, 20, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(14);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(30);
    checks++; if (obs_pulses != p0) begin failures++; $display("FAIL middiv_pulses: got %0d expected 0", obs_pulses - p0); end
    checks++; if (o_X_pos !== 16'd801) begin failures++; $display("FAIL middiv_x: got %0d expected 801", o_X_pos); end
    checks++; if (o_Y_pos !== 16'd601) begin failures++; $display("FAIL middiv_y: got %0d expected 601", o_Y_pos); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL middiv_busy: got %0b expected 0", busy); end
  endtask

`ifdef DETECT_SMOOTH_EN
  task automatic test_smooth;
    fill(20, 100, 100, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(36);
    checks++; if (o_X_pos !== 16'd100 || o_Y_pos !== 16'd100) begin failures++; $display("FAIL smooth_first: got %0d,%0d expected 100,100", o_X_pos, o_Y_pos); end
    fill(20, 200, 300, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(36);
    checks++; if (o_X_pos !== 16'd150 || o_Y_pos !== 16'd200) begin failures++; $display("FAIL smooth_second: got %0d,%0d expected 150,200", o_X_pos, o_Y_pos); end
  endtask
`endif

  initial begin
    test_reset;
    test_no_match;
    test_square;
    test_below_min;
    test_back_to_back;
    test_nf_ef;
    test_random;
    test_reset_mid_div;
`ifdef DETECT_SMOOTH_EN
    test_smooth;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
